// File: rtl/uart_frame_parser.sv
// Framing stage behind the UART RX FIFO: hunts for SOF, buffers a length-prefixed
// payload, verifies the additive checksum, then streams the payload out valid/ready.
module uart_frame_parser #(
  parameter int              dbit   = 8,
  parameter int              maxlen = 16,
  parameter logic [dbit-1:0] sof    = 8'hA5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [dbit-1:0] rdata,
  input  logic            rxempty,
  output logic            rduart,
  input  logic [15:0]     timeout_cycles,
  output logic [dbit-1:0] pdata,
  output logic            pvalid,
  output logic            plast,
  input  logic            pready,
  output logic            frame_ok,
  output logic            frame_err,
  output logic [1:0]      err_code,
  output logic [15:0]     frame_cnt,
  output logic [15:0]     err_cnt
);
  localparam int              AW     = (maxlen > 1) ? $clog2(maxlen) : 1;
  localparam logic [dbit-1:0] MAXLEN = dbit'(maxlen);

  typedef enum logic [2:0] {S_HUNT, S_LEN, S_DATA, S_CHK, S_EMIT} state_t;

  state_t          state_q, state_d;
  logic            rduart_q, rduart_d, pend_q, pend_d;
  logic [15:0]     tmo_q, tmo_d, tmo_inc;
  logic [dbit-1:0] len_q, len_d, sum_q, sum_d, idx_q, idx_d, idx_inc, chk_sum;
  logic [dbit-1:0] pdata_q, pdata_d;
  logic            pvalid_q, pvalid_d, plast_q, plast_d;
  logic            frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
  logic [1:0]      err_code_q, err_code_d, err_val;
  logic [15:0]     frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
  logic            buf_we, err_now;
  logic [dbit-1:0] buf_q [2**AW];

  always_comb begin
    state_d     = state_q;
    pend_d      = rduart_q;  // byte is on rdata the cycle after the pop
    tmo_d       = tmo_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    pdata_d     = pdata_q;
    pvalid_d    = pvalid_q;
    plast_d     = plast_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    buf_we      = 1'b0;
    err_now     = 1'b0;
    err_val     = 2'd0;
    chk_sum     = sum_q + rdata;
    tmo_inc     = tmo_q + 16'd1;
    idx_inc     = idx_q + dbit'(1);

    case (state_q)
      S_HUNT: begin
        tmo_d = '0;
        if (pend_q && rdata == sof) state_d = S_LEN;
      end
      S_LEN: if (pend_q) begin
        if (rdata == '0 || rdata > MAXLEN) begin
          err_now = 1'b1;
          err_val = 2'd1;
        end else begin
          len_d   = rdata;
          sum_d   = rdata;
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: if (pend_q) begin
        buf_we = 1'b1;
        sum_d  = chk_sum;
        idx_d  = idx_inc;
        if (idx_inc == len_q) state_d = S_CHK;
      end
      S_CHK: if (pend_q) begin
        if (chk_sum == '0) begin
          frame_ok_d  = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_EMIT;
          pvalid_d    = 1'b1;
          pdata_d     = buf_q[0];
          plast_d     = (len_q == dbit'(1));
          idx_d       = dbit'(1);
        end else begin
          err_now = 1'b1;
          err_val = 2'd2;
        end
      end
      S_EMIT: if (pvalid_q && pready) begin
        if (plast_q) begin
          pvalid_d = 1'b0;
          plast_d  = 1'b0;
          state_d  = S_HUNT;
          tmo_d    = '0;
        end else begin
          pdata_d = buf_q[idx_q[AW-1:0]];
          plast_d = (idx_inc == len_q);
          idx_d   = idx_inc;
        end
      end
      default: state_d = S_HUNT;
    endcase

    // Inter-byte timeout only counts idle cycles, not cycles spent waiting on a pop.
    if (state_q inside {S_LEN, S_DATA, S_CHK}) begin
      if (pend_q) tmo_d = '0;
      else if (!rduart_q) begin
        tmo_d = tmo_inc;
        if (timeout_cycles != '0 && tmo_inc == timeout_cycles) begin
          err_now = 1'b1;
          err_val = 2'd3;
        end
      end
    end

    if (err_now) begin
      frame_err_d = 1'b1;
      err_code_d  = err_val;
      err_cnt_d   = err_cnt_q + 16'd1;
      state_d     = S_HUNT;
      tmo_d       = '0;
    end

    // Decided on the next state so the CHK capture cycle never pops into EMIT.
    rduart_d = (state_d != S_EMIT) && !rxempty && !rduart_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_HUNT;
      rduart_q    <= 1'b0;
      pend_q      <= 1'b0;
      tmo_q       <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      pdata_q     <= '0;
      pvalid_q    <= 1'b0;
      plast_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'd0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rduart_q    <= rduart_d;
      pend_q      <= pend_d;
      tmo_q       <= tmo_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      pdata_q     <= pdata_d;
      pvalid_q    <= pvalid_d;
      plast_q     <= plast_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) buf_q[idx_q[AW-1:0]] <= rdata;
  end

  assign rduart    = rduart_q;
  assign pdata     = pdata_q;
  assign pvalid    = pvalid_q;
  assign plast     = plast_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: FIFO model feeds frames, a payload
// scoreboard checks the output stream, status counters are checked per step.
module tb_uart_frame_parser;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rdata = 8'h00;
  logic        rxempty;
  logic        rduart;
  logic [15:0] timeout_cycles = 16'd0;
  logic [7:0]  pdata;
  logic        pvalid, plast;
  logic        pready = 1'b1;
  logic        frame_ok, frame_err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt, err_cnt;

  uart_frame_parser #(.dbit(8), .maxlen(16), .sof(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .rdata(rdata), .rxempty(rxempty), .rduart(rduart),
    .timeout_cycles(timeout_cycles), .pdata(pdata), .pvalid(pvalid), .plast(plast),
    .pready(pready), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Receive FIFO model: data appears on rdata the cycle after a pop.
  logic [7:0] mem [256];
  logic [7:0] wr_ptr = 8'd0, rd_ptr = 8'd0;
  assign rxempty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (rduart && rd_ptr != wr_ptr) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 8'd1;
    end
  end

  int         n_cmp = 0, n_bad = 0, cyc = 0, n_ok = 0, n_err = 0;
  int         exp_frames = 0, exp_errs = 0, last_rd = 0, err_cyc = 0, pmode = 0;
  logic [1:0] last_code = 2'd0;
  logic [8:0] exp_q [$];
  logic [8:0] held = 9'd0;
  bit         stall_prev = 0, prev_more = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [8:0] e;
    @(negedge clk);
    cyc++;
    case (pmode)
      0:       pready = 1'b1;
      1:       pready = cyc[1];
      default: pready = 1'b0;
    endcase
    if (stall_prev) begin
      chk("stall_valid", pvalid, 1);
      chk("stall_data", {plast, pdata}, held);
    end
    if (prev_more) chk("b2b_valid", pvalid, 1);
    chk("ok_err_excl", frame_ok & frame_err, 0);
    if (frame_ok) begin
      n_ok++;
      chk("ok_pvalid", pvalid, 1);
    end
    if (frame_err) begin
      n_err++;
      last_code = err_code;
      err_cyc = cyc;
    end
    if (rduart) last_rd = cyc;
    if (pvalid) chk("emit_no_rd", rduart, 0);
    if (pvalid && pready) begin
      if (exp_q.size() == 0) chk("spurious_byte", pvalid & pready, 0);
      else begin
        e = exp_q.pop_front();
        chk("payload", {plast, pdata}, e);
      end
    end
    stall_prev = pvalid && !pready && reset_n;
    prev_more  = pvalid && pready && !plast && reset_n;
    held       = {plast, pdata};
  endtask

  // code: 0 good frame, 1..3 expected error, -1 bytes with no framing outcome
  task automatic send(input logic [7:0] b[$], input int code);
    foreach (b[i]) begin
      mem[wr_ptr] = b[i];
      wr_ptr++;
    end
    if (code == 0) begin
      exp_frames++;
      for (int i = 0; i < int'(b[1]); i++) exp_q.push_back({i == int'(b[1]) - 1, b[2+i]});
    end else if (code > 0) exp_errs++;
  endtask

  task automatic drain(input string tag, input int code);
    bit done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      tick();
      if (rd_ptr == wr_ptr && exp_q.size() == 0 && !pvalid) done = 1;
    end
    repeat (6) tick();
    chk({tag, "_drained"}, done, 1);
    chk({tag, "_frame_cnt"}, frame_cnt, exp_frames);
    chk({tag, "_err_cnt"}, err_cnt, exp_errs);
    chk({tag, "_ok_pulses"}, n_ok, exp_frames);
    chk({tag, "_err_pulses"}, n_err, exp_errs);
    if (code > 0) chk({tag, "_err_code"}, err_code, code);
  endtask

  initial begin
    logic [7:0] q [$];
    int n0, d;
    bit fired;

    repeat (3) tick();
    chk("rst_rduart", rduart, 0);
    chk("rst_pvalid", pvalid, 0);
    chk("rst_plast", plast, 0);
    chk("rst_pdata", pdata, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}, 0);
    drain("good", 0);

    send('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00}, 2);
    drain("badchk", 2);
    send('{8'hA5, 8'h01, 8'h7F, 8'h80}, 0);
    drain("after_badchk", 0);

    send('{8'hA5, 8'h00}, 1);
    drain("len_zero", 1);
    send('{8'hA5, 8'h11}, 1);
    drain("len_over", 1);
    send('{8'h11}, -1);
    send('{8'hA5, 8'h01, 8'h05, 8'hFA}, 0);
    drain("after_len", 0);

    // LEN == maxlen is the largest accepted frame
    q = '{8'hA5, 8'h10};
    for (int i = 1; i <= 16; i++) q.push_back(8'(i));
    q.push_back(8'h68);
    send(q, 0);
    drain("len_max", 0);

    // A rejected LEN byte equal to SOF must not restart a frame
    send('{8'hA5, 8'hA5}, 1);
    send('{8'h01, 8'h05, 8'hFA}, -1);
    drain("len_sof", 1);

    send('{8'h00, 8'hFF, 8'hA4}, -1);
    send('{8'hA5, 8'h01, 8'hAA, 8'h55}, 0);
    drain("garbage", 0);

    // Pulse lands just after the 20th idle cycle following capture of 01;
    // capture is the cycle after the last pop strobe.
    timeout_cycles = 16'd20;
    n0 = n_err;
    fired = 0;
    send('{8'hA5, 8'h02, 8'h01}, 3);
    for (int k = 0; k < 80 && !fired; k++) begin
      tick();
      if (n_err != n0) fired = 1;
    end
    d = err_cyc - last_rd;
    chk("tmo_fired", fired, 1);
    chk("tmo_code", err_code, 3);
    chk("tmo_window", (d >= 21 && d <= 23), 1);
    drain("tmo", 3);

    timeout_cycles = 16'd0;
    send('{8'hA5, 8'h02, 8'h01}, -1);
    repeat (300) tick();
    chk("tmo_off_no_err", n_err, exp_errs);
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b1, 8'h02});
    exp_frames++;
    send('{8'h02, 8'hFB}, -1);
    drain("tmo_off", 0);

    pmode = 1;
    send('{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2}, 0);
    send('{8'h00, 8'h00, 8'h00}, -1);
    drain("backpressure", 0);

    pmode = 2;
    fired = 0;
    send('{8'hA5, 8'h01, 8'h33, 8'hCC}, 0);
    for (int k = 0; k < 40 && !fired; k++) begin
      tick();
      if (pvalid) fired = 1;
    end
    chk("rst_emit_valid", pvalid, 1);
    reset_n = 1'b0;
    stall_prev = 0;
    tick();
    chk("rst_emit_pvalid", pvalid, 0);
    chk("rst_emit_plast", plast, 0);
    chk("rst_emit_pdata", pdata, 0);
    chk("rst_emit_frame_cnt", frame_cnt, 0);
    chk("rst_emit_err_cnt", err_cnt, 0);
    chk("rst_emit_err_code", err_code, 0);
    exp_q.delete();
    pmode = 0;
    reset_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_pvalid", pvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
